fifo_umbral: RTL and testbench
==============================

# fifo_umbral

Synchronous, parameterized FIFO with programmable almost-full/almost-empty thresholds. It provides the per-queue status the QoS control FSM consumes: empty, error, and threshold "pause" flags. Five instances, one per VC/D/MF queue, feed the FSM's FIFO_EMPTIES/FIFO_ERRORS buses. Each instance takes its threshold values from the FSM's latched Umbral outputs.

## Interface
Parameters:
- DATA_WIDTH, 6, width of each stored word
- ADDR_WIDTH, 2, log2 of depth (depth = 2**ADDR_WIDTH = 4)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- push  in  1  write request; data_in written on the edge when accepted
- data_in  in  DATA_WIDTH  write data
- pop  in  1  read request
- umbral_alto  in  ADDR_WIDTH+1  almost-full threshold (count ≥ value)
- umbral_bajo  in  ADDR_WIDTH+1  almost-empty threshold (count ≤ value)
- data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  one-cycle strobe: data_out holds a freshly popped word
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == depth
- almost_full  out  1  count ≥ umbral_alto (pause request to upstream)
- almost_empty  out  1  count ≤ umbral_bajo
- fifo_error  out  1  overflow/underflow indication
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth

## Operation
- Storage: depth × DATA_WIDTH register array.
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrap modulo depth. Occupancy is tracked by count (ADDR_WIDTH+1 bits), never by pointer difference.
- Accepted push = push && (!fifo_full || pop). Accepted pop = pop && !fifo_empty.
- Accepted push: mem[wr_ptr] ← data_in, wr_ptr+1.
- Accepted pop: data_out ← mem[rd_ptr], rd_ptr+1, valid_out=1 next cycle.
- count next = count + acc_push − acc_pop.
- Full with push && pop: both accepted, count unchanged, no error.
- Empty with push && pop: push accepted, pop rejected (no bypass). Underflow error is raised; count becomes 1.
- Overflow = push && fifo_full && !pop. The word is dropped and pointers are unchanged.
- Underflow = pop && fifo_empty. data_out holds its value and valid_out stays 0.
- Thresholds are sampled live every cycle. A threshold change takes effect in the flags on the next edge.
  - umbral_alto = 0 forces almost_full=1.
  - umbral_bajo ≥ depth forces almost_empty=1.
- fifo_error behaviour: see Configuration.
- Reset clears pointers, count and memory contents are don't-care; memory need not be cleared.

## Timing
- All outputs are registered and computed from next-state count, so flags reflect occupancy after the edge.
- Reset values (reset high at an edge):
  - data_out=0, valid_out=0, count=0, fifo_empty=1, fifo_full=0, almost_full=0, fifo_error=0
  - almost_empty=1 for any umbral_bajo, since 0 ≤ value
- Reset mid-operation takes priority over push/pop on the same edge. Stored words are discarded.
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1; data_out and valid_out appear after edge N+1.
- Pop-to-data latency: 1 cycle.
- A pop request in cycle N yields valid_out high for exactly the cycle after edge N. Back-to-back pops give a continuous valid_out.
- fifo_empty and fifo_full are never both 1. count is never > depth.

## Configuration
- FIFO_ERROR_STICKY_EN
  - Defined: fifo_error is set by the first overflow or underflow and stays 1 until reset. This matches the FSM's ERROR state, which exits only through reset.
  - Undefined: fifo_error is a one-cycle pulse, registered 1 on the edge following each overflow/underflow event, otherwise 0.

## Test plan
- Reset: hold reset=1 for 2 edges with push=pop=1 → count=0, fifo_empty=1, almost_empty=1, fifo_error=0, valid_out=0.
- Fill/drain ordering (umbral_alto=3, umbral_bajo=1):
  - Push 0x01,0x02,0x03,0x04 on consecutive edges → almost_full rises after the 3rd push, fifo_full after the 4th.
  - Pop 4 times → data_out 0x01..0x04 in order, valid_out high 4 consecutive cycles, almost_empty rises when count=1.
- Overflow: on a full FIFO, push 0x3F alone → count stays 4, fifo_error=1.
  - Then pop all 4 → the 0x3F never appears.
  - With the macro, fifo_error stays 1 until reset; without it, fifo_error pulses for 1 cycle.
- Underflow: on an empty FIFO, pop → valid_out=0, data_out unchanged, fifo_error asserted per the macro.
- Simultaneous push+pop:
  - On full: count stays 4, popped word is the oldest, no error.
  - On empty: count→1, fifo_error asserted, next pop returns the pushed word.
- Wrap-around and mid-operation reset:
  - Run 10 interleaved push/pop pairs → data order is preserved across the pointer wrap.
  - Assert reset with count=3 → fifo_empty=1 and count=0 on the next cycle; a subsequent push/pop returns only new data.

Source files
------------

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and status flags.
// Optional macro FIFO_ERROR_STICKY_EN: fifo_error latches until reset instead of pulsing.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  acc_push, acc_pop, err_event;
  logic [ADDR_WIDTH:0]   count_next;

  // Acceptance is judged against the registered flags; a full FIFO still
  // accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    count_next = count;
    acc_push   = push && (!fifo_full || pop);
    acc_pop    = pop && !fifo_empty;
    err_event  = (push && fifo_full && !pop) || (pop && fifo_empty);
    if (acc_push && !acc_pop)
      count_next = count + (ADDR_WIDTH + 1)'(1);
    else if (!acc_push && acc_pop)
      count_next = count - (ADDR_WIDTH + 1)'(1);
  end

  // NOTE: storage has no reset; pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (!reset && acc_push)
      mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      fifo_error   <= 1'b0;
    end else begin
      if (acc_push)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (acc_pop) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      valid_out    <= acc_pop;
      count        <= count_next;
      // Flags describe the occupancy that exists after this edge.
      fifo_empty   <= (count_next == '0);
      fifo_full    <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= umbral_alto);
      almost_empty <= (count_next <= umbral_bajo);
`ifdef FIFO_ERROR_STICKY_EN
      fifo_error   <= fifo_error || err_event;
`else
      fifo_error   <= err_event;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Randomized and directed bench for fifo_umbral against a queue-based reference model.
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_alto, umbral_bajo;
  logic [DW-1:0] data_out;
  logic          valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error;
  logic [AW:0]   count;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: contents as a queue, plus expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid, m_err, m_af, m_ae;
  logic [AW:0]   ua, ub;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic p, input logic po, input logic [DW-1:0] d);
    int  n;
    bit  ap, au, ev;
    @(negedge clk);
    reset = r; push = p; pop = po; data_in = d;
    umbral_alto = ua; umbral_bajo = ub;
    n = q.size();
    if (r) begin
      q.delete();
      m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_af = 1'b0; m_ae = 1'b1;
    end else begin
      ev = (p && n == DEPTH && !po) || (po && n == 0);
      au = po && n > 0;
      ap = p && (n < DEPTH || po);
      m_valid = au;
      if (au) m_data = q.pop_front();
      if (ap) q.push_back(d);
`ifdef FIFO_ERROR_STICKY_EN
      m_err = m_err || ev;
`else
      m_err = ev;
`endif
      m_af = (q.size() >= int'(ua));
      m_ae = (q.size() <= int'(ub));
    end
    @(posedge clk);
    #1;
    check("count",        32'(count),        32'(q.size()));
    check("fifo_empty",   32'(fifo_empty),   32'(q.size() == 0));
    check("fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
    check("valid_out",    32'(valid_out),    32'(m_valid));
    check("data_out",     32'(data_out),     32'(m_data));
    check("almost_full",  32'(almost_full),  32'(m_af));
    check("almost_empty", 32'(almost_empty), 32'(m_ae));
    check("fifo_error",   32'(fifo_error),   32'(m_err));
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    ua = 3'd3; ub = 3'd1;
    umbral_alto = ua; umbral_bajo = ub;
    m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_af = 1'b0; m_ae = 1'b1;

    // Reset held two edges while push and pop are requested.
    step(1, 1, 1, 6'h15);
    step(1, 1, 1, 6'h2A);

    // Fill then drain in order.
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 6'(i));
    for (int i = 0; i < 4; i++)  step(0, 0, 1, 6'h00);

    // Overflow drops the word; error pulse or latch is visible on the idle cycle.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6'(8 + i));
    step(0, 1, 0, 6'h3F);
    step(0, 0, 0, 6'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 6'h00);

    // Underflow on empty, then reset to clear any latched error.
    step(0, 0, 1, 6'h00);
    step(0, 0, 0, 6'h00);
    step(1, 0, 0, 6'h00);

    // Simultaneous push and pop on full, then on empty.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6'(16 + i));
    step(0, 1, 1, 6'h2B);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 6'h00);
    step(0, 1, 1, 6'h31);
    step(0, 0, 1, 6'h00);
    step(1, 0, 0, 6'h00);

    // Interleaved pairs across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 6'(32 + i));
      step(0, 0, 1, 6'h00);
    end

    // Mid-operation reset with three stored words.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 6'(40 + i));
    step(1, 1, 1, 6'h3E);
    step(0, 1, 0, 6'h22);
    step(0, 0, 1, 6'h00);

    // Threshold boundaries: alto=0 forces almost_full, bajo>=depth forces almost_empty.
    ua = 3'd0; ub = 3'd4;
    step(0, 0, 0, 6'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 6'(48 + i));
    ua = 3'd4; ub = 3'd0;
    step(0, 0, 0, 6'h00);
    step(0, 0, 1, 6'h00);

    // Random traffic with occasional threshold changes and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        ua = 3'($urandom_range(0, 7));
        ub = 3'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
